icache_lines: RTL

Parametrised direct-mapped instruction cache with multi-word lines, critical-word-first refill and flush. It sits between the fetch stage and a single Wishbone-style read port, the same port shape as `wb_simulator`. It replaces the fixed 16-entry, five-port cache with one memory port and a configurable geometry.

---
 rtl/icache_lines.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/icache_lines.sv
// Direct-mapped instruction cache with multi-word lines, critical-word-first refill and flush.
// Define ICACHE_STATS_EN to add the hit_cnt/miss_cnt statistics outputs.
module icache_lines #(
  parameter int LINES = 8,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic        flush,
  output logic [31:0] inst,
  output logic        ack,
  output logic        busy,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_busy,
  input  logic        mem_valid
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);
  localparam int OB = $clog2(WORDS);
  localparam int IB = $clog2(LINES);
  localparam int TB = 30 - OB - IB;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RESP      = 2'd1,
    FILL_REQ  = 2'd2,
    FILL_WAIT = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [LINES-1:0] valid_r;
  logic [TB-1:0]    tag_mem_r  [LINES];
  logic [31:0]      data_mem_r [LINES*WORDS];
  logic [TB-1:0]    tag_r;
  logic [IB-1:0]    idx_r;
  logic [OB-1:0]    off_r;
  logic [OB-1:0]    beat_r;
  logic             flushed_r;

  logic [TB-1:0]    req_tag_s;
  logic [IB-1:0]    req_idx_s;
  logic [OB-1:0]    req_off_s;
  logic             hit_s;
  logic             accept_s;
  logic             fill_beat_s;
  logic             last_beat_s;
  logic [OB-1:0]    word_s;
  logic [OB-1:0]    next_word_s;
  logic             unused_s;

  assign req_tag_s   = addr[31 -: TB];
  assign req_idx_s   = addr[2+OB +: IB];
  assign req_off_s   = addr[2 +: OB];
  assign unused_s    = ^addr[1:0];
  // A flush in the same cycle wins, so the request is forced to miss.
  assign hit_s       = valid_r[req_idx_s] && (tag_mem_r[req_idx_s] == req_tag_s) && !flush;
  assign accept_s    = (state_r == IDLE) && req;
  assign fill_beat_s = (state_r == FILL_WAIT) && mem_valid;
  assign last_beat_s = (beat_r == OB'(WORDS - 1));
  assign word_s      = off_r + beat_r;
  assign next_word_s = word_s + OB'(1);
  assign mem_req     = (state_r == FILL_REQ) && !mem_busy;

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req) begin
          state_s = hit_s ? RESP : FILL_REQ;
        end else begin
          state_s = IDLE;
        end
      end
      RESP: state_s = IDLE;
      FILL_REQ: begin
        if (!mem_busy) begin
          state_s = FILL_WAIT;
        end else begin
          state_s = FILL_REQ;
        end
      end
      FILL_WAIT: begin
        if (mem_valid) begin
          state_s = last_beat_s ? IDLE : FILL_REQ;
        end else begin
          state_s = FILL_WAIT;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Control state, valid bits and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      valid_r   <= '0;
      tag_r     <= '0;
      idx_r     <= '0;
      off_r     <= '0;
      beat_r    <= '0;
      flushed_r <= 1'b0;
      ack       <= 1'b0;
      inst      <= 32'd0;
      busy      <= 1'b0;
      mem_addr  <= 32'd0;
    end else begin
      state_r <= state_s;
      busy    <= (state_s != IDLE);
      ack     <= 1'b0;
      if (accept_s) begin
        tag_r     <= req_tag_s;
        idx_r     <= req_idx_s;
        off_r     <= req_off_s;
        beat_r    <= '0;
        flushed_r <= 1'b0;
        if (hit_s) begin
          ack  <= 1'b1;
          inst <= data_mem_r[{req_idx_s, req_off_s}];
        end else begin
          mem_addr <= {req_tag_s, req_idx_s, req_off_s, 2'b00};
        end
      end else if (flush && (state_r != IDLE)) begin
        flushed_r <= 1'b1;
      end
      if (fill_beat_s) begin
        if (beat_r == '0) begin
          ack  <= 1'b1;
          inst <= mem_rdata;
        end
        if (last_beat_s) begin
          valid_r[idx_r] <= !flushed_r;
        end else begin
          beat_r   <= beat_r + OB'(1);
          mem_addr <= {tag_r, idx_r, next_word_s, 2'b00};
        end
      end
      // Placed last so a flush on the final beat still leaves the line invalid.
      if (flush) begin
        valid_r <= '0;
      end
    end
  end

  // Line storage; valid_r guards the unreset contents.
  always_ff @(posedge clk) begin
    if (fill_beat_s) begin
      data_mem_r[{idx_r, word_s}] <= mem_rdata;
      if (last_beat_s) begin
        tag_mem_r[idx_r] <= tag_r;
      end
    end
  end

`ifdef ICACHE_STATS_EN
  // Hit/miss counters, untouched by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= 32'd0;
      miss_cnt <= 32'd0;
    end else if (accept_s) begin
      if (hit_s) begin
        hit_cnt <= hit_cnt + 32'd1;
      end else begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
